gpu_instruction_decoder: RTL and testbench
==========================================

# gpu_instruction_decoder

Responder-side decode unit for the GPU main controller. When the controller grants `decode_en`, this block pops instruction words from the command FIFO, decodes them, and parks draw instructions in a 2-entry decoded-instruction buffer that the draw engine drains. Toward the controller it reports `decode_fin`, `decode_full` and `inst_type`, which are the status inputs the controller's DECODE/DEC&DRAW/DRAW/ALPHA sequencing depends on.

## Interface
- No parameters. Word width is fixed at 32 and buffer depth at 2.
- `clk` in 1: clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `decode_en` in 1: controller grant. It only gates the *start* of a new instruction.
- `fifo_empty` in 1: command FIFO is empty.
- `fifo_rdata` in 32: show-ahead FIFO head word, valid whenever `!fifo_empty`.
- `fifo_r_en` out 1: pops the FIFO head this cycle. Combinational.
- `draw_take` in 1: draw engine consumes the buffer head.
- `out_valid` out 1: buffer head valid.
- `shape_type` out 2: 01 LINE, 10 RECT, 11 FILL_RECT. Field of the buffer head.
- `color` out 24: field of the buffer head.
- `x0`, `y0`, `x1`, `y1` out 8 each: fields of the buffer head.
- `decode_fin` out 1: one-cycle pulse per committed draw instruction.
- `decode_full` out 1: buffer holds 2 entries.
- `inst_type` out 1: ALPHA instruction decoded and pending.
- `alpha_val` out 8: alpha value of the last ALPHA instruction.
- `err` out 1: sticky flag, illegal opcode seen.

## Operation
- Word0 format: [31:29] opcode, [28:24] reserved, [23:0] color (or alpha value in [7:0]).
- Word1 format: {x0, y0, x1, y1}, 8 bits each, MSB first.
- Opcodes:
  - 000: NOP, 1 word, discarded.
  - 001: LINE, 2 words.
  - 010: RECT, 2 words.
  - 011: FILL_RECT, 2 words.
  - 100: ALPHA, 1 word.
  - 101–111: illegal, 1 word, discarded, `err` set.
- FSM states: IDLE, FETCH1, COMMIT, ALPHA_HOLD.
- **IDLE:** if `decode_en && !fifo_empty && !decode_full`, assert `fifo_r_en` and latch word0.
  - NOP or illegal: stay in IDLE.
  - ALPHA: latch `alpha_val` = word0[7:0] and go to ALPHA_HOLD.
  - Draw opcode: latch opcode and color, go to FETCH1.
- **FETCH1:** wait while `fifo_empty`. When a word is present, assert `fifo_r_en`, latch coordinates, go to COMMIT. This completes even if `decode_en` has dropped.
- **COMMIT:** `decode_fin`=1. The entry is written into the buffer at the end of this cycle. Then go to IDLE.
- **ALPHA_HOLD:** `inst_type`=1 and no FIFO reads. Exit to IDLE on the first cycle `decode_en`=0 is sampled; `inst_type` is 0 from the next cycle.
- Buffer is a 2-entry circular FIFO with a 2-bit count.
  - `out_valid` = (count != 0).
  - `decode_full` = (count == 2).
  - Outputs show the head entry; the fields are don't-care when `out_valid`=0.
- `draw_take` with `out_valid`=1 pops the head. `draw_take` with `out_valid`=0 is ignored.
- Commit and take in the same cycle: both happen, count is unchanged.
- COMMIT can never find the buffer full, because an instruction only starts when `!decode_full` and only this block writes the buffer.
- `err` clears only on reset.

## Timing
- Reset value of every output is 0, including `fifo_r_en` (held 0 during reset). FSM resets to IDLE, buffer count to 0.
- Two-word instruction with FIFO data available: pop word0 in cycle N, word1 in N+1, `decode_fin` in N+2, `out_valid`/fields updated in N+3.
- Peak throughput is 1 draw instruction per 3 cycles. Each cycle `fifo_empty` stays high in FETCH1 adds one cycle.
- ALPHA: pop in cycle N, `inst_type` and `alpha_val` valid from N+1.
- `decode_fin` and `inst_type` are never high in the same cycle.
- `draw_take` at the end of cycle M: `decode_full` drops in M+1, and a new instruction may start in M+1.
- Reset mid-instruction abandons the partial instruction and clears the buffer. Words already popped are lost.

## Test plan
- **LINE then RECT.** FIFO holds 0x20FF0000/0x01020304 then 0x4000FF00/0x10102020, `decode_en`=1, no `draw_take`. Required:
  - `decode_fin` pulses at cycles 2 and 5.
  - Head shows shape 01, color FF0000, coordinates 1,2,3,4.
  - `decode_full`=1 after the second commit, and no further `fifo_r_en`.
- **Simultaneous commit and take.** Buffer holds 1 entry; assert `draw_take` in the COMMIT cycle. Required: count stays 1, and the head becomes the new entry.
- **ALPHA.** FIFO holds 0x80000080. Required:
  - `inst_type`=1 and `alpha_val`=0x80 from cycle 1.
  - `inst_type` stays high while `decode_en`=1.
  - `inst_type` falls one cycle after `decode_en`=0.
- **Starved FETCH1.** Word0 is 0x60123456 and `fifo_empty`=1 for 4 cycles before word1 arrives. Required: `decode_fin` is delayed by exactly 4 cycles, and FILL_RECT commits correctly.
- **NOP and illegal.** 0x00000000 then 0xE0000000. Required: both popped, no `decode_fin`, `err`=1 and stays 1.
- **Reset during FETCH1.** Required: all outputs are 0 immediately (asynchronous), and decoding resumes cleanly from IDLE afterwards.

Source files
------------

// File: rtl/gpu_instruction_decoder.sv
// gpu_instruction_decoder
// Pops instruction words from the command FIFO while the controller grants
// decode_en, decodes them, and parks draw instructions in a 2-entry buffer
// drained by the draw engine. ALPHA instructions are held as a status toward
// the controller instead of being buffered.
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   decode_en             controller grant; gates only the start of an instruction
//   fifo_empty/fifo_rdata show-ahead command FIFO head
//   fifo_r_en             FIFO pop (combinational)
//   draw_take             draw engine consumes the buffer head
//   out_valid, shape_type, color, x0, y0, x1, y1   buffer head
//   decode_fin            one-cycle pulse per committed draw instruction
//   decode_full           buffer holds two entries
//   inst_type             ALPHA instruction decoded and pending
//   alpha_val             alpha value of the last ALPHA instruction
//   err                   sticky illegal-opcode flag
module gpu_instruction_decoder (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        decode_en,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_rdata,
  output logic        fifo_r_en,
  input  logic        draw_take,
  output logic        out_valid,
  output logic [1:0]  shape_type,
  output logic [23:0] color,
  output logic [7:0]  x0,
  output logic [7:0]  y0,
  output logic [7:0]  x1,
  output logic [7:0]  y1,
  output logic        decode_fin,
  output logic        decode_full,
  output logic        inst_type,
  output logic [7:0]  alpha_val,
  output logic        err
);

  localparam int unsigned SHAPE_W = 2;
  localparam int unsigned COLOR_W = 24;
  localparam int unsigned COORD_W = 32;
  localparam int unsigned ALPHA_W = 8;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 2;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LINE  = 3'b001;
  localparam logic [2:0] OP_RECT  = 3'b010;
  localparam logic [2:0] OP_FILL  = 3'b011;
  localparam logic [2:0] OP_ALPHA = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_FETCH1     = 2'd1,
    S_COMMIT     = 2'd2,
    S_ALPHA_HOLD = 2'd3
  } state_e;

  typedef struct packed {
    logic [SHAPE_W-1:0] shape;
    logic [COLOR_W-1:0] color;
    logic [COORD_W-1:0] coords;
  } entry_t;

  state_e               state_q, state_d;
  entry_t               pend_q, pend_d;
  logic [ALPHA_W-1:0]   alpha_q, alpha_d;
  logic                 err_q, err_d;
  entry_t               buf_q [DEPTH];
  entry_t               buf_d [DEPTH];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [2:0]           opcode;
  logic                 push;
  logic                 pop;
  entry_t               head;

  assign opcode      = fifo_rdata[31:29];
  assign decode_full = (count_q == CNT_W'(DEPTH));
  assign out_valid   = (count_q != CNT_W'(0));
  assign head        = buf_q[rd_ptr_q];
  assign shape_type  = head.shape;
  assign color       = head.color;
  assign {x0, y0, x1, y1} = head.coords;
  assign alpha_val   = alpha_q;
  assign err         = err_q;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (fifo_r_en) begin
          case (opcode)
            OP_LINE, OP_RECT, OP_FILL: state_d = S_FETCH1;
            OP_ALPHA:                  state_d = S_ALPHA_HOLD;
            default:                   state_d = S_IDLE;
          endcase
        end
      end
      S_FETCH1:     if (fifo_r_en) state_d = S_COMMIT;
      S_COMMIT:     state_d = S_IDLE;
      S_ALPHA_HOLD: if (!decode_en) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // FSM outputs; fifo_r_en is forced low while reset is asserted so no word
  // is lost to a pop the FSM cannot act on.
  always_comb begin
    fifo_r_en  = 1'b0;
    decode_fin = 1'b0;
    inst_type  = 1'b0;
    unique case (state_q)
      S_IDLE:       fifo_r_en  = n_rst && decode_en && !fifo_empty && !decode_full;
      S_FETCH1:     fifo_r_en  = n_rst && !fifo_empty;
      S_COMMIT:     decode_fin = 1'b1;
      S_ALPHA_HOLD: inst_type  = 1'b1;
      default:      ;
    endcase
  end

  // Word capture, alpha/err status and decoded-instruction buffer
  always_comb begin
    pend_d   = pend_q;
    alpha_d  = alpha_q;
    err_d    = err_q;
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if ((state_q == S_IDLE) && fifo_r_en) begin
      case (opcode)
        OP_LINE, OP_RECT, OP_FILL: begin
          pend_d.shape = opcode[SHAPE_W-1:0];
          pend_d.color = fifo_rdata[COLOR_W-1:0];
        end
        OP_ALPHA: alpha_d = fifo_rdata[ALPHA_W-1:0];
        OP_NOP:   ;
        default:  err_d = 1'b1;
      endcase
    end

    if ((state_q == S_FETCH1) && fifo_r_en) begin
      pend_d.coords = fifo_rdata;
    end

    // Commit never meets a full buffer: starts are blocked while full.
    push = decode_fin;
    pop  = draw_take && out_valid;
    if (push) begin
      buf_d[wr_ptr_q] = pend_q;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend_q   <= '0;
      alpha_q  <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      pend_q   <= pend_d;
      alpha_q  <= alpha_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_gpu_instruction_decoder.sv
// Bench for gpu_instruction_decoder: a queue-based command FIFO model feeds
// the decoder, expected draw entries are queued as instructions are loaded,
// and a monitor compares the buffer head every time the draw engine takes it.
module tb_gpu_instruction_decoder;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        decode_en = 1'b0;
  logic        fifo_empty;
  logic [31:0] fifo_rdata;
  logic        fifo_r_en;
  logic        draw_take = 1'b0;
  logic        out_valid;
  logic [1:0]  shape_type;
  logic [23:0] color;
  logic [7:0]  x0, y0, x1, y1;
  logic        decode_fin, decode_full, inst_type;
  logic [7:0]  alpha_val;
  logic        err;

  always #5 clk = ~clk;

  gpu_instruction_decoder dut (
    .clk(clk), .n_rst(n_rst), .decode_en(decode_en),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_r_en(fifo_r_en),
    .draw_take(draw_take), .out_valid(out_valid), .shape_type(shape_type),
    .color(color), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .decode_fin(decode_fin), .decode_full(decode_full), .inst_type(inst_type),
    .alpha_val(alpha_val), .err(err)
  );

  logic [31:0] fq [$];
  logic [57:0] exp_q [$];
  logic        hold_empty = 1'b0;
  logic        pop_seen = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] fin_m, ren_m, inst_m, full_m, valid_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void drive_fifo();
    fifo_empty = hold_empty || (fq.size() == 0);
    fifo_rdata = (fq.size() != 0) ? fq[0] : 32'h0;
  endfunction

  // FIFO model: the pop request seen mid-cycle is the one the DUT acts on.
  always @(negedge clk) pop_seen = fifo_r_en;
  always @(posedge clk) begin
    #1;
    if (pop_seen && fq.size() != 0) void'(fq.pop_front());
    drive_fifo();
  end

  // Scoreboard monitor: every accepted take must match the oldest expected entry.
  always @(negedge clk) begin
    if (n_rst && out_valid && draw_take) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL draw_entry: unexpected take of %0h, nothing expected",
                 {shape_type, color, x0, y0, x1, y1});
      end else begin
        chk("draw_entry", 64'({shape_type, color, x0, y0, x1, y1}), 64'(exp_q.pop_front()));
      end
    end
  end

  // Run n cycles with per-cycle decode_en/draw_take/forced-empty masks,
  // recording the status outputs of each cycle as bit masks.
  task automatic run(input int n, input logic [31:0] en_m, input logic [31:0] take_m,
                     input logic [31:0] hold_m);
    fin_m = '0; ren_m = '0; inst_m = '0; full_m = '0; valid_m = '0;
    for (int k = 0; k < n; k++) begin
      decode_en  = en_m[k];
      draw_take  = take_m[k];
      hold_empty = hold_m[k];
      drive_fifo();
      @(negedge clk);
      fin_m[k]   = decode_fin;
      ren_m[k]   = fifo_r_en;
      inst_m[k]  = inst_type;
      full_m[k]  = decode_full;
      valid_m[k] = out_valid;
      @(posedge clk);
      #1;
    end
    decode_en  = 1'b0;
    draw_take  = 1'b0;
    hold_empty = 1'b0;
    drive_fifo();
  endtask

  initial begin
    drive_fifo();
    #2;
    chk("reset_flags", 64'({fifo_r_en, out_valid, decode_fin, decode_full, inst_type, err}), 64'h0);
    chk("reset_fields", 64'({shape_type, color, x0, y0, x1, y1, alpha_val}), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk);
    #1;

    // LINE then RECT, followed by a NOP that must wait for buffer space
    fq.push_back(32'h20FF0000); fq.push_back(32'h01020304);
    fq.push_back(32'h4000FF00); fq.push_back(32'h10102020);
    fq.push_back(32'h00000000);
    exp_q.push_back({2'b01, 24'hFF0000, 32'h01020304});
    exp_q.push_back({2'b10, 24'h00FF00, 32'h10102020});
    run(10, 32'hFFFFFFFF, 32'h0, 32'h0);
    chk("t1_fin", 64'(fin_m), 64'h24);
    chk("t1_ren", 64'(ren_m), 64'h1B);
    chk("t1_full", 64'(full_m), 64'h3C0);
    chk("t1_valid", 64'(valid_m), 64'h3F8);
    chk("t1_inst", 64'(inst_m), 64'h0);
    run(3, 32'hFFFFFFFF, 32'h3, 32'h0);
    chk("t1_drain_valid", 64'(valid_m), 64'h3);
    chk("t1_drain_full", 64'(full_m), 64'h1);
    chk("t1_drain_ren", 64'(ren_m), 64'h2);

    // Commit and take in the same cycle
    fq.push_back(32'h2000000F); fq.push_back(32'h05060708);
    fq.push_back(32'h40123456); fq.push_back(32'h090A0B0C);
    exp_q.push_back({2'b01, 24'h00000F, 32'h05060708});
    exp_q.push_back({2'b10, 24'h123456, 32'h090A0B0C});
    run(9, 32'hFFFFFFFF, 32'hA0, 32'h0);
    chk("t2_fin", 64'(fin_m), 64'h24);
    chk("t2_valid", 64'(valid_m), 64'hF8);
    chk("t2_full", 64'(full_m), 64'h0);

    // ALPHA held until decode_en drops
    fq.push_back(32'h80000080);
    run(8, 32'h1F, 32'h0, 32'h0);
    chk("t3_inst", 64'(inst_m), 64'h3E);
    chk("t3_ren", 64'(ren_m), 64'h1);
    chk("t3_fin", 64'(fin_m), 64'h0);
    chk("t3_alpha", 64'(alpha_val), 64'h80);

    // FETCH1 starved for 4 cycles
    fq.push_back(32'h60123456); fq.push_back(32'h0A0B0C0D);
    exp_q.push_back({2'b11, 24'h123456, 32'h0A0B0C0D});
    run(9, 32'hFFFFFFFF, 32'h80, 32'h1E);
    chk("t4_fin", 64'(fin_m), 64'h40);
    chk("t4_ren", 64'(ren_m), 64'h21);
    chk("t4_valid", 64'(valid_m), 64'h80);

    // NOP and illegal opcode
    chk("t5_err_before", 64'(err), 64'h0);
    fq.push_back(32'h00000000); fq.push_back(32'hE0000000);
    run(6, 32'hFFFFFFFF, 32'h0, 32'h0);
    chk("t5_ren", 64'(ren_m), 64'h3);
    chk("t5_fin", 64'(fin_m), 64'h0);
    chk("t5_valid", 64'(valid_m), 64'h0);
    chk("t5_err", 64'(err), 64'h1);
    run(3, 32'h0, 32'h0, 32'h0);
    chk("t5_err_sticky", 64'(err), 64'h1);

    // Reset during FETCH1
    fq.push_back(32'h20AA0000); fq.push_back(32'h01020304);
    run(1, 32'h1, 32'h0, 32'h0);
    decode_en = 1'b1;
    #1;
    chk("t6_fetch1_ren", 64'(fifo_r_en), 64'h1);
    n_rst = 1'b0;
    #1;
    chk("t6_rst_flags", 64'({fifo_r_en, out_valid, decode_fin, decode_full, inst_type, err}), 64'h0);
    chk("t6_rst_fields", 64'({shape_type, color, x0, y0, x1, y1, alpha_val}), 64'h0);
    decode_en = 1'b0;
    fq.delete();
    drive_fifo();
    repeat (2) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk);
    #1;
    fq.push_back(32'h40ABCDEF); fq.push_back(32'h11223344);
    exp_q.push_back({2'b10, 24'hABCDEF, 32'h11223344});
    run(5, 32'hFFFFFFFF, 32'h08, 32'h0);
    chk("t6_fin", 64'(fin_m), 64'h4);
    chk("t6_ren", 64'(ren_m), 64'h3);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
